// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the writeback arbiter.
// Holds the producer port indices, the x0 register index and the
// modulo-N pointer helper used by both the arbiter and the top.
package wb_arbiter_pkg;

    // Producer port indices into the src_* vectors
    localparam int WB_PORT_IP0 = 0;
    localparam int WB_PORT_IP1 = 1;
    localparam int WB_PORT_LSP = 2;

    // Architectural zero register; writes to it are dropped
    localparam logic [4:0] REG_ZERO = 5'd0;

    // (base + off) mod nport, valid when base < nport and off < nport
    function automatic int wrap_idx(input int base, input int off, input int nport);
        int sum;
        sum = base + off;
        if (sum >= nport) begin
            sum = sum - nport;
        end else begin
            sum = sum;
        end
        return sum;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans requests starting at ptr and wrapping; the first one found wins.
// Returns a one-hot grant, its encoded index and an any-grant flag.
// Kept generic so the issue-side select can reuse it.
module rr_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NPORT = 3,
    parameter int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic [NPORT-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NPORT-1:0] gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Priority scan from ptr; only the first valid candidate is granted
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            int cand;
            cand = wrap_idx(int'(ptr), k, NPORT);
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = IDX_W'(cand);
                any       = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback stage: round-robin selects one completed result per cycle,
// drives the register-file write port and scoreboard clear, and counts
// retired instructions in minstret.
// Optional build macro WB_TRACE_EN adds a registered retire-trace port set.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NPORT = 3,
    parameter int CNT_W = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORT-1:0]      src_valid,
    output logic [NPORT-1:0]      src_ready,
    input  logic [5*NPORT-1:0]    src_dst,
    input  logic [64*NPORT-1:0]   src_result,
    input  logic [64*NPORT-1:0]   src_pc,
    input  logic [NPORT-1:0]      src_wb_en,
    output logic                  rf_wr_en,
    output logic [4:0]            rf_wr_id,
    output logic [63:0]           rf_wr_data,
    output logic                  wb_ix_clear,
    input  logic                  csr_minstret_we,
    input  logic [CNT_W-1:0]      csr_minstret_wd,
`ifdef WB_TRACE_EN
    output logic                  trace_valid,
    output logic [63:0]           trace_pc,
    output logic [4:0]            trace_dst,
    output logic                  trace_wb_en,
    output logic [63:0]           trace_data,
`endif
    output logic [CNT_W-1:0]      minstret
);

    localparam int IDX_W = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [IDX_W-1:0] rr_ptr_r;
    logic [NPORT-1:0] req_s;
    logic [NPORT-1:0] gnt_s;
    logic [IDX_W-1:0] gnt_idx_s;
    logic             gnt_any_s;
    logic [4:0]       sel_dst_s;
    logic [63:0]      sel_data_s;
    logic [63:0]      sel_pc_s;
    logic             wr_en_s;
    logic [CNT_W-1:0] minstret_r;

    // Mask requests during reset so nothing is acknowledged
    always_comb begin
        req_s = '0;
        if (rst) begin
            req_s = '0;
        end else begin
            req_s = src_valid;
        end
    end

    rr_arbiter #(
        .NPORT (NPORT),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (req_s),
        .ptr (rr_ptr_r),
        .gnt (gnt_s),
        .idx (gnt_idx_s),
        .any (gnt_any_s)
    );

    // Slice out the granted producer's payload and qualify the write
    always_comb begin
        sel_dst_s  = src_dst[int'(gnt_idx_s)*5 +: 5];
        sel_data_s = src_result[int'(gnt_idx_s)*64 +: 64];
        sel_pc_s   = src_pc[int'(gnt_idx_s)*64 +: 64];
        wr_en_s    = 1'b0;
        if (gnt_any_s && src_wb_en[gnt_idx_s] && (sel_dst_s != REG_ZERO)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    assign src_ready   = gnt_s;
    assign rf_wr_en    = wr_en_s;
    assign wb_ix_clear = wr_en_s;
    assign rf_wr_id    = sel_dst_s;
    assign rf_wr_data  = sel_data_s;
    assign minstret    = minstret_r;

    // Round-robin pointer moves past the winner; holds when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (gnt_any_s) begin
            rr_ptr_r <= IDX_W'(wrap_idx(int'(gnt_idx_s), 1, NPORT));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Retired-instruction counter; a CSR write overrides the same-cycle retire
    always_ff @(posedge clk) begin
        if (rst) begin
            minstret_r <= '0;
        end else if (csr_minstret_we) begin
            minstret_r <= csr_minstret_wd;
        end else if (gnt_any_s) begin
            minstret_r <= minstret_r + CNT_W'(1);
        end else begin
            minstret_r <= minstret_r;
        end
    end

`ifdef WB_TRACE_EN
    logic        trace_valid_r;
    logic [63:0] trace_pc_r;
    logic [4:0]  trace_dst_r;
    logic        trace_wb_en_r;
    logic [63:0] trace_data_r;

    // Capture each retired instruction for one cycle of trace output
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_valid_r <= 1'b0;
            trace_pc_r    <= 64'd0;
            trace_dst_r   <= 5'd0;
            trace_wb_en_r <= 1'b0;
            trace_data_r  <= 64'd0;
        end else if (gnt_any_s) begin
            trace_valid_r <= 1'b1;
            trace_pc_r    <= sel_pc_s;
            trace_dst_r   <= sel_dst_s;
            trace_wb_en_r <= wr_en_s;
            trace_data_r  <= sel_data_s;
        end else begin
            trace_valid_r <= 1'b0;
            trace_pc_r    <= trace_pc_r;
            trace_dst_r   <= trace_dst_r;
            trace_wb_en_r <= trace_wb_en_r;
            trace_data_r  <= trace_data_r;
        end
    end

    assign trace_valid = trace_valid_r;
    assign trace_pc    = trace_pc_r;
    assign trace_dst   = trace_dst_r;
    assign trace_wb_en = trace_wb_en_r;
    assign trace_data  = trace_data_r;
`else
    logic unused_pc_s;
    assign unused_pc_s = ^sel_pc_s;
`endif

endmodule
